// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, multi-cycle EX sequencing, and flush handling.
// Combinational stall/flush outputs from registered FSM and load-scoreboard state; 16-bit saturating ID-stall counter.
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_reg1_read_i,
    input  logic [4:0]  id_reg1_addr_i,
    input  logic        id_reg2_read_i,
    input  logic [4:0]  id_reg2_addr_i,
    input  logic        id_wreg_i,
    input  logic [4:0]  id_wd_i,
    input  logic        id_is_load_i,
    input  logic        ex_mc_req_i,
    input  logic [3:0]  ex_mc_cycles_i,
    input  logic        flush_i,
    output logic [5:0]  stall_o,
    output logic        flush_o,
    output logic        mc_done_o,
    output logic [15:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mc_state_t;

    mc_state_t   state;
    mc_state_t   state_nxt;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nxt;
    logic        mc_stall;
    logic        ld_v;
    logic        ld_v_nxt;
    logic [4:0]  ld_addr;
    logic [4:0]  ld_addr_nxt;
    logic        load_use;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            ld_v        <= 1'b0;
            ld_addr     <= 5'd0;
            stall_cnt_o <= 16'd0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            ld_v    <= ld_v_nxt;
            ld_addr <= ld_addr_nxt;
            if (stall_o[2] && (stall_cnt_o != 16'hFFFF)) begin
                stall_cnt_o <= stall_cnt_o + 16'd1;
            end
        end
    end

    // The request cycle itself counts as the first stall cycle, so cnt holds N-1 remaining.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mc_stall  = 1'b0;
        case (state)
            IDLE: begin
                if (ex_mc_req_i && (ex_mc_cycles_i != 4'd0)) begin
                    mc_stall  = 1'b1;
                    cnt_nxt   = ex_mc_cycles_i - 4'd1;
                    state_nxt = (ex_mc_cycles_i >= 4'd2) ? BUSY : DONE;
                end
            end
            BUSY: begin
                mc_stall = 1'b1;
                cnt_nxt  = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
        if (flush_i) begin
            state_nxt = IDLE;
            cnt_nxt   = 4'd0;
        end
    end

    assign load_use = ld_v && (ld_addr != 5'd0) &&
                      ((id_reg1_read_i && (id_reg1_addr_i == ld_addr)) ||
                       (id_reg2_read_i && (id_reg2_addr_i == ld_addr)));

    // A load-use stall injects a bubble into EX, so the scoreboard entry retires.
    always_comb begin
        ld_v_nxt    = ld_v;
        ld_addr_nxt = ld_addr;
        if (flush_i) begin
            ld_v_nxt = 1'b0;
        end else if (mc_stall) begin
            ld_v_nxt = ld_v;
        end else if (load_use) begin
            ld_v_nxt = 1'b0;
        end else begin
            ld_v_nxt    = id_is_load_i & id_wreg_i & (id_wd_i != 5'd0);
            ld_addr_nxt = id_wd_i;
        end
    end

    always_comb begin
        stall_o = 6'b000000;
        if (rst && !flush_i) begin
            if (mc_stall) begin
                stall_o = 6'b001111;
            end else if (load_use) begin
                stall_o = 6'b000111;
            end
        end
    end

    assign flush_o   = flush_i;
    assign mc_done_o = (state == DONE);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scenario bench for hazard_ctrl: expected outputs are queued as stimulus is driven and popped at the sample point.
module tb_hazard_ctrl;

    localparam logic [5:0] S0  = 6'b000000;
    localparam logic [5:0] SMC = 6'b001111;
    localparam logic [5:0] SLU = 6'b000111;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        id_reg1_read_i = 1'b0;
    logic [4:0]  id_reg1_addr_i = 5'd0;
    logic        id_reg2_read_i = 1'b0;
    logic [4:0]  id_reg2_addr_i = 5'd0;
    logic        id_wreg_i = 1'b0;
    logic [4:0]  id_wd_i = 5'd0;
    logic        id_is_load_i = 1'b0;
    logic        ex_mc_req_i = 1'b0;
    logic [3:0]  ex_mc_cycles_i = 4'd0;
    logic        flush_i = 1'b0;
    logic [5:0]  stall_o;
    logic        flush_o;
    logic        mc_done_o;
    logic [15:0] stall_cnt_o;

    typedef struct packed {
        logic       r1rd;
        logic [4:0] r1a;
        logic       r2rd;
        logic [4:0] r2a;
        logic       ld;
        logic       wreg;
        logic [4:0] wd;
        logic       mcreq;
        logic [3:0] mcn;
        logic       fl;
        logic [5:0] stall;
        logic       done;
    } vec_t;

    typedef struct packed {
        logic [5:0] stall;
        logic       done;
        logic       flush;
    } exp_t;

    exp_t        sb[$];
    int          nvec = 0;
    int          nerr = 0;
    logic [15:0] exp_cnt = 16'd0;

    hazard_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .id_reg1_read_i (id_reg1_read_i),
        .id_reg1_addr_i (id_reg1_addr_i),
        .id_reg2_read_i (id_reg2_read_i),
        .id_reg2_addr_i (id_reg2_addr_i),
        .id_wreg_i      (id_wreg_i),
        .id_wd_i        (id_wd_i),
        .id_is_load_i   (id_is_load_i),
        .ex_mc_req_i    (ex_mc_req_i),
        .ex_mc_cycles_i (ex_mc_cycles_i),
        .flush_i        (flush_i),
        .stall_o        (stall_o),
        .flush_o        (flush_o),
        .mc_done_o      (mc_done_o),
        .stall_cnt_o    (stall_cnt_o)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r1rd, input logic [4:0] r1a,
                                input logic r2rd, input logic [4:0] r2a,
                                input logic ld, input logic wreg, input logic [4:0] wd,
                                input logic mcreq, input logic [3:0] mcn, input logic fl,
                                input logic [5:0] stall, input logic done);
        vec_t v;
        v = '{r1rd, r1a, r2rd, r2a, ld, wreg, wd, mcreq, mcn, fl, stall, done};
        return v;
    endfunction

    task automatic drive(input vec_t v);
        id_reg1_read_i = v.r1rd;
        id_reg1_addr_i = v.r1a;
        id_reg2_read_i = v.r2rd;
        id_reg2_addr_i = v.r2a;
        id_is_load_i   = v.ld;
        id_wreg_i      = v.wreg;
        id_wd_i        = v.wd;
        ex_mc_req_i    = v.mcreq;
        ex_mc_cycles_i = v.mcn;
        flush_i        = v.fl;
    endtask

    task automatic test_reset();
        ex_mc_req_i = 1'b1;
        ex_mc_cycles_i = 4'd3;
        flush_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        nvec += 4;
        if (stall_o !== S0) begin nerr++; $display("FAIL rst_stall got %b exp %b", stall_o, S0); end
        if (mc_done_o !== 1'b0) begin nerr++; $display("FAIL rst_done got %b exp 0", mc_done_o); end
        if (stall_cnt_o !== 16'd0) begin nerr++; $display("FAIL rst_cnt got %h exp 0000", stall_cnt_o); end
        if (flush_o !== 1'b1) begin nerr++; $display("FAIL rst_flush got %b exp 1", flush_o); end
        flush_i = 1'b0;
        #1;
        nvec++;
        if (flush_o !== 1'b0) begin nerr++; $display("FAIL rst_flush0 got %b exp 0", flush_o); end
        drive('0);
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_load_use();
        vec_t vs[$];
        exp_t e;
        vs.push_back(mk(0,0, 0,0, 1,1,3, 0,0,0, S0, 0));
        vs.push_back(mk(0,0, 1,3, 0,0,0, 0,0,0, SLU,0));
        vs.push_back(mk(0,0, 1,3, 0,0,0, 0,0,0, S0, 0));
        vs.push_back(mk(0,0, 0,0, 1,1,7, 0,0,0, S0, 0));
        vs.push_back(mk(1,7, 0,0, 0,0,0, 0,0,0, SLU,0));
        vs.push_back(mk(1,7, 0,0, 0,0,0, 0,0,0, S0, 0));
        vs.push_back(mk(0,0, 0,0, 1,1,9, 0,0,0, S0, 0));
        vs.push_back(mk(0,9, 1,4, 0,0,0, 0,0,0, S0, 0));
        vs.push_back(mk(0,0, 0,0, 1,0,5, 0,0,0, S0, 0));
        vs.push_back(mk(1,5, 1,5, 0,0,0, 0,0,0, S0, 0));
        vs.push_back(mk(0,0, 0,0, 1,1,0, 0,0,0, S0, 0));
        vs.push_back(mk(1,0, 1,0, 0,0,0, 0,0,0, S0, 0));
        foreach (vs[i]) begin
            drive(vs[i]);
            sb.push_back('{vs[i].stall, vs[i].done, vs[i].fl});
            @(negedge clk);
            e = sb.pop_front();
            nvec += 4;
            if (stall_o !== e.stall) begin nerr++; $display("FAIL lu_stall[%0d] got %b exp %b", i, stall_o, e.stall); end
            if (mc_done_o !== e.done) begin nerr++; $display("FAIL lu_done[%0d] got %b exp %b", i, mc_done_o, e.done); end
            if (flush_o !== e.flush) begin nerr++; $display("FAIL lu_flush[%0d] got %b exp %b", i, flush_o, e.flush); end
            if (stall_cnt_o !== exp_cnt) begin nerr++; $display("FAIL lu_cnt[%0d] got %0d exp %0d", i, stall_cnt_o, exp_cnt); end
            if (e.stall[2] && exp_cnt != 16'hFFFF) exp_cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_multicycle();
        vec_t vs[$];
        exp_t e;
        vs.push_back(mk(0,0, 0,0, 0,0,0, 1,3,0, SMC,0));
        vs.push_back(mk(0,0, 0,0, 0,0,0, 1,3,0, SMC,0));
        vs.push_back(mk(0,0, 0,0, 0,0,0, 1,3,0, SMC,0));
        vs.push_back(mk(0,0, 0,0, 0,0,0, 1,3,0, S0, 1));
        vs.push_back(mk(0,0, 0,0, 0,0,0, 0,0,0, S0, 0));
        vs.push_back(mk(0,0, 0,0, 0,0,0, 1,1,0, SMC,0));
        vs.push_back(mk(0,0, 0,0, 0,0,0, 1,1,0, S0, 1));
        vs.push_back(mk(0,0, 0,0, 0,0,0, 0,0,0, S0, 0));
        vs.push_back(mk(0,0, 0,0, 0,0,0, 1,0,0, S0, 0));
        vs.push_back(mk(0,0, 0,0, 0,0,0, 0,0,0, S0, 0));
        vs.push_back(mk(0,0, 0,0, 1,1,4, 0,0,0, S0, 0));
        vs.push_back(mk(1,4, 0,0, 0,0,0, 1,2,0, SMC,0));
        vs.push_back(mk(1,4, 0,0, 0,0,0, 1,2,0, SMC,0));
        vs.push_back(mk(1,4, 0,0, 0,0,0, 0,0,0, SLU,1));
        vs.push_back(mk(1,4, 0,0, 0,0,0, 0,0,0, S0, 0));
        foreach (vs[i]) begin
            drive(vs[i]);
            sb.push_back('{vs[i].stall, vs[i].done, vs[i].fl});
            @(negedge clk);
            e = sb.pop_front();
            nvec += 4;
            if (stall_o !== e.stall) begin nerr++; $display("FAIL mc_stall[%0d] got %b exp %b", i, stall_o, e.stall); end
            if (mc_done_o !== e.done) begin nerr++; $display("FAIL mc_done[%0d] got %b exp %b", i, mc_done_o, e.done); end
            if (flush_o !== e.flush) begin nerr++; $display("FAIL mc_flush[%0d] got %b exp %b", i, flush_o, e.flush); end
            if (stall_cnt_o !== exp_cnt) begin nerr++; $display("FAIL mc_cnt[%0d] got %0d exp %0d", i, stall_cnt_o, exp_cnt); end
            if (e.stall[2] && exp_cnt != 16'hFFFF) exp_cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_flush();
        vec_t vs[$];
        exp_t e;
        vs.push_back(mk(0,0, 0,0, 1,1,6, 0,0,0, S0, 0));
        vs.push_back(mk(0,0, 1,6, 0,0,0, 1,7,0, SMC,0));
        vs.push_back(mk(0,0, 1,6, 0,0,0, 1,7,0, SMC,0));
        vs.push_back(mk(0,0, 1,6, 0,0,0, 1,7,1, S0, 0));
        vs.push_back(mk(0,0, 1,6, 0,0,0, 0,0,0, S0, 0));
        vs.push_back(mk(0,0, 0,0, 0,0,0, 1,4,1, S0, 0));
        vs.push_back(mk(0,0, 0,0, 0,0,0, 0,0,0, S0, 0));
        vs.push_back(mk(0,0, 0,0, 1,1,2, 0,0,0, S0, 0));
        vs.push_back(mk(1,2, 0,0, 0,0,0, 0,0,1, S0, 0));
        vs.push_back(mk(1,2, 0,0, 0,0,0, 0,0,0, S0, 0));
        foreach (vs[i]) begin
            drive(vs[i]);
            sb.push_back('{vs[i].stall, vs[i].done, vs[i].fl});
            @(negedge clk);
            e = sb.pop_front();
            nvec += 4;
            if (stall_o !== e.stall) begin nerr++; $display("FAIL fl_stall[%0d] got %b exp %b", i, stall_o, e.stall); end
            if (mc_done_o !== e.done) begin nerr++; $display("FAIL fl_done[%0d] got %b exp %b", i, mc_done_o, e.done); end
            if (flush_o !== e.flush) begin nerr++; $display("FAIL fl_flush[%0d] got %b exp %b", i, flush_o, e.flush); end
            if (stall_cnt_o !== exp_cnt) begin nerr++; $display("FAIL fl_cnt[%0d] got %0d exp %0d", i, stall_cnt_o, exp_cnt); end
            if (e.stall[2] && exp_cnt != 16'hFFFF) exp_cnt++;
            @(posedge clk); #1;
        end
    endtask

    // Back-to-back N=15 ops give 15 stall cycles per 16, enough to pass 65535 within 70000 cycles.
    task automatic test_saturate();
        drive(mk(0,0, 0,0, 0,0,0, 1,15,0, S0, 0));
        repeat (70000) @(posedge clk);
        @(negedge clk);
        nvec++;
        if (stall_cnt_o !== 16'hFFFF) begin nerr++; $display("FAIL sat_cnt got %h exp ffff", stall_cnt_o); end
        @(posedge clk); #1;
        drive(mk(0,0, 0,0, 0,0,0, 0,0,1, S0, 0));
        @(posedge clk); #1;
        drive('0);
        @(negedge clk);
        nvec++;
        if (stall_cnt_o !== 16'hFFFF) begin nerr++; $display("FAIL sat_hold got %h exp ffff", stall_cnt_o); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_busy();
        drive(mk(0,0, 0,0, 0,0,0, 1,8,0, S0, 0));
        @(posedge clk); #1;
        @(negedge clk);
        nvec++;
        if (stall_o !== SMC) begin nerr++; $display("FAIL rb_busy got %b exp %b", stall_o, SMC); end
        #2;
        rst = 1'b0;
        #1;
        nvec += 4;
        if (stall_o !== S0) begin nerr++; $display("FAIL rb_stall got %b exp %b", stall_o, S0); end
        if (mc_done_o !== 1'b0) begin nerr++; $display("FAIL rb_done got %b exp 0", mc_done_o); end
        if (stall_cnt_o !== 16'd0) begin nerr++; $display("FAIL rb_cnt got %h exp 0000", stall_cnt_o); end
        if (flush_o !== 1'b0) begin nerr++; $display("FAIL rb_flush got %b exp 0", flush_o); end
        drive('0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            nvec += 3;
            if (stall_o !== S0) begin nerr++; $display("FAIL rb_post_stall[%0d] got %b exp %b", k, stall_o, S0); end
            if (mc_done_o !== 1'b0) begin nerr++; $display("FAIL rb_post_done[%0d] got %b exp 0", k, mc_done_o); end
            if (stall_cnt_o !== 16'd0) begin nerr++; $display("FAIL rb_post_cnt[%0d] got %h exp 0000", k, stall_cnt_o); end
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_multicycle();
        test_flush();
        test_saturate();
        test_reset_busy();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have one clock, clk (input, 1): all state updates on its rising edge.
REQ-002 SHALL have reset rst (input, 1): asynchronous, active-low (rst=0 resets immediately, independent of clk).
REQ-003 SHALL have id_reg1_read_i (input, 1): decode stage reads operand 1 from the regfile.
REQ-004 SHALL have id_reg1_addr_i (input, 5): operand 1 register address.
REQ-005 SHALL have id_reg2_read_i (input, 1): decode stage reads operand 2 from the regfile.
REQ-006 SHALL have id_reg2_addr_i (input, 5): operand 2 register address.
REQ-007 SHALL have id_wreg_i (input, 1) and id_wd_i (input, 5): decoded instruction writes register id_wd_i.
REQ-008 SHALL have id_is_load_i (input, 1): decoded instruction is a memory load.
REQ-009 SHALL have ex_mc_req_i (input, 1) and ex_mc_cycles_i (input, 4): EX holds a multi-cycle op needing N=ex_mc_cycles_i cycles.
REQ-010 SHALL have flush_i (input, 1): branch/exception flush request.
REQ-011 SHALL have stall_o (output, 6): bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb; 1 = hold stage.
REQ-012 SHALL have flush_o (output, 1), mc_done_o (output, 1), stall_cnt_o (output, 16).

Function
REQ-013 SHALL keep a one-entry load scoreboard {ld_v, ld_addr} for the instruction currently in EX.
REQ-014 Load-use hazard SHALL be: ld_v=1 and ((id_reg1_read_i and id_reg1_addr_i==ld_addr) or (id_reg2_read_i and id_reg2_addr_i==ld_addr)); ld_addr 0 never hazards.
REQ-015 MC FSM SHALL have states IDLE, BUSY, DONE and a 4-bit down-counter cnt.
REQ-016 IDLE with ex_mc_req_i=1 and N>=1: stall this cycle, cnt<=N-1, next BUSY if N>=2 else DONE; N=0 is single-cycle, no stall, stay IDLE.
REQ-017 BUSY: stall every cycle, cnt<=cnt-1, next DONE when cnt==1, else stay BUSY; total stall = exactly N cycles including the request cycle.
REQ-018 DONE: mc_done_o=1, no MC stall, ex_mc_req_i ignored, next IDLE.
REQ-019 stall_o priority (combinational): flush_i=1 -> 6'b000000; else MC stall -> 6'b001111; else load-use -> 6'b000111; else 6'b000000.
REQ-020 flush_o SHALL equal flush_i in the same cycle.
REQ-021 Scoreboard update: flush_i -> ld_v<=0; MC stall -> hold; load-use stall -> ld_v<=0 (bubble to EX); else ld_v<=id_is_load_i & id_wreg_i & (id_wd_i!=0), ld_addr<=id_wd_i.
REQ-022 flush_i=1 in any state SHALL force next state IDLE, cnt<=0, and overrides a simultaneous ex_mc_req_i.
REQ-023 stall_cnt_o SHALL increment each cycle stall_o[2]=1, saturating at 16'hFFFF (no wrap).
REQ-024 A load-use condition present during BUSY SHALL be re-evaluated on leaving MC stall; no stall cycle is lost or duplicated.

Reset
REQ-025 rst=0 SHALL immediately clear: state=IDLE, cnt=0, ld_v=0, ld_addr=0, stall_cnt_o=0; stall_o=0, flush_o=flush_i, mc_done_o=0.
REQ-026 Reset asserted mid-BUSY SHALL abort the op; after release FSM is IDLE with no residual stall.

Verification
REQ-027 Load r3 into EX, ID reads r3 as operand 2 -> stall_o=000111 for 1 cycle, then 000000; stall_cnt_o=1.
REQ-028 Load r0 followed by ID reading r0 -> no stall.
REQ-029 ex_mc_req_i=1, N=3 -> stall_o=001111 for 3 cycles, then mc_done_o=1 for 1 cycle, IDLE.
REQ-030 ex_mc_req_i=1, N=1 -> 1 stall cycle then DONE; N=0 -> no stall.
REQ-031 flush_i=1 during BUSY with cnt=5 -> stall_o=0, flush_o=1 same cycle, IDLE next cycle, ld_v=0.
REQ-032 Hold stall for 70000 cycles -> stall_cnt_o saturates at 16'hFFFF; rst=0 mid-BUSY -> all outputs zero asynchronously.
